iter_square: RTL and testbench
==============================

ITER_SQUARE -- requirements
Module: iter_square

Interface
REQ-001 Parameter IN_WIDTH, default 16, is the width of the signed operand.
REQ-002 Parameter OUT_WIDTH, default 2*IN_WIDTH, is the width of the unsigned square; values other than 2*IN_WIDTH are unsupported.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request to square x_in; sampled only in IDLE.
REQ-006 x_in  input  IN_WIDTH  signed two's-complement operand.
REQ-007 y_out  output  OUT_WIDTH  unsigned square |x_in|^2 of the last completed operation.
REQ-008 done  output  1  one-cycle pulse marking y_out and is_neg as freshly valid.
REQ-009 is_neg  output  1  set when the operand of the last accepted operation was negative.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN and FIN; done is high iff state is FIN, and busy is high iff state is not IDLE.
REQ-012 In IDLE with start=1, the block SHALL capture mag = |x_in| as an IN_WIDTH-bit unsigned value, latch is_neg = x_in[IN_WIDTH-1], clear the accumulator, load iter = IN_WIDTH and go to RUN.
REQ-013 For x_in = -2^(IN_WIDTH-1), mag SHALL be 2^(IN_WIDTH-1) with no overflow, because mag is unsigned.
REQ-014 Each RUN cycle SHALL do: acc += (multiplier[0] ? multiplicand : 0); multiplicand <<= 1; multiplier >>= 1; iter -= 1.
REQ-015 multiplicand and acc are OUT_WIDTH bits wide, and the multiplier is IN_WIDTH bits wide, so the sum can never truncate.
REQ-016 On the RUN cycle with iter==1, the block SHALL load the final accumulator sum into y_out and go to FIN.
REQ-017 FIN SHALL last exactly one cycle and then go unconditionally to IDLE.
REQ-018 Latency: start is sampled at edge E and done is high in the cycle after edge E+IN_WIDTH, i.e. IN_WIDTH+1 cycles after acceptance (17 cycles at the default width).
REQ-019 y_out and is_neg SHALL hold their values from FIN until the next completion or reset, and SHALL not change during RUN.
REQ-020 start SHALL be ignored in RUN and FIN; x_in is don't-care outside the accept cycle.
REQ-021 Back-to-back operation: if start is held high, the next operation is accepted in the IDLE cycle after FIN, giving a throughput of one result per IN_WIDTH+2 cycles.
REQ-022 x_in = 0 SHALL still take the full IN_WIDTH RUN cycles, so latency is data-independent.

Reset
REQ-023 While rst_n=0 at a clock edge, the block SHALL set state = IDLE and clear y_out, is_neg, the accumulator, the multiplicand, the multiplier and iter.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse, and the block SHALL accept start in the first cycle after rst_n rises.
REQ-025 All outputs read 0 after reset: done=0, busy=0, y_out=0, is_neg=0.

Structure
REQ-026 The state typedef (IDLE, RUN, FIN, 2-bit encoding) SHALL live in the shared arithmetic package math_pkg, so that all iterative arithmetic blocks use one encoding.
REQ-027 The block SHALL be a single module with no sub-module; the only datapath is the shift-add adder.
REQ-028 The iteration counter SHALL be sized $clog2(IN_WIDTH+1).

Verification
REQ-029 x_in=0, start pulse -> done 17 cycles later, y_out=0, is_neg=0, busy high for 17 cycles.
REQ-030 x_in=255 -> y_out=65025, is_neg=0; x_in=32767 -> y_out=1073676289.
REQ-031 x_in=-3 -> y_out=9, is_neg=1; x_in=-32768 -> y_out=0x4000_0000, is_neg=1.
REQ-032 Accept x_in=7, then pulse start with x_in=100 during RUN -> result 49, and only one done pulse.
REQ-033 start held high with x_in=12 then 5 -> done pulses 18 cycles apart, y_out=144 then 25, and y_out stable between the pulses.
REQ-034 Accept x_in=9, assert rst_n=0 at RUN cycle 8 -> no done, y_out=0; after release, x_in=9 -> 81.

Source files
------------

// File: rtl/math_pkg.sv
// Shared definitions for the iterative arithmetic blocks: one FSM state
// encoding used by every multi-cycle operator.
package math_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/iter_square_if.sv
// Request/result bundle for iter_square: the requester drives start/x_in,
// the squarer returns the result, its sign flag and status.
interface iter_square_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
);

  logic                 start;
  logic [IN_WIDTH-1:0]  x_in;
  logic [OUT_WIDTH-1:0] y_out;
  logic                 done;
  logic                 is_neg;
  logic                 busy;

  modport master (output start, x_in, input y_out, done, is_neg, busy);
  modport slave  (input start, x_in, output y_out, done, is_neg, busy);

endinterface

// File: rtl/iter_square.sv
// Sequential squarer: |x_in|^2 by one shift-add step per cycle, IN_WIDTH
// steps per operation, so latency does not depend on the operand value.
module iter_square
  import math_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  iter_square_if.slave sq
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0]    ITER_LOAD = CNT_W'(IN_WIDTH);
  localparam logic [CNT_W-1:0]    ITER_ONE  = CNT_W'(1);
  localparam logic [IN_WIDTH-1:0] IN_ONE    = IN_WIDTH'(1);

  state_e               state, state_next;
  logic [IN_WIDTH-1:0]  mag;
  logic [IN_WIDTH-1:0]  multiplier;
  logic [OUT_WIDTH-1:0] multiplicand;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_sum;
  logic [OUT_WIDTH-1:0] y_reg;
  logic [CNT_W-1:0]     iter;
  logic                 neg_pend;
  logic                 neg_reg;
  logic                 last_step;

  // Magnitude is unsigned, so -2^(IN_WIDTH-1) maps to 2^(IN_WIDTH-1) cleanly.
  assign mag       = sq.x_in[IN_WIDTH-1] ? (~sq.x_in + IN_ONE) : sq.x_in;
  assign acc_sum   = acc + (multiplier[0] ? multiplicand : '0);
  assign last_step = (iter == ITER_ONE);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sq.start) state_next = RUN;
      RUN:     if (last_step) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every datapath register is cleared on reset so an aborted operation
  // leaves no stale partial product behind and all outputs read zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      multiplier   <= '0;
      multiplicand <= '0;
      acc          <= '0;
      iter         <= '0;
      neg_pend     <= 1'b0;
      neg_reg      <= 1'b0;
      y_reg        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sq.start) begin
            multiplier   <= mag;
            multiplicand <= OUT_WIDTH'(mag);
            acc          <= '0;
            iter         <= ITER_LOAD;
            neg_pend     <= sq.x_in[IN_WIDTH-1];
          end
        end
        RUN: begin
          acc          <= acc_sum;
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          iter         <= iter - ITER_ONE;
          // Result and sign publish together so they only change on completion.
          if (last_step) begin
            y_reg   <= acc_sum;
            neg_reg <= neg_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign sq.y_out  = y_reg;
  assign sq.is_neg = neg_reg;
  assign sq.done   = (state == FIN);
  assign sq.busy   = (state != IDLE);

endmodule

// File: tb/tb_iter_square.sv
// Directed bench for iter_square at default width: latency, results, sign,
// start-ignore, back-to-back throughput and mid-operation reset.
module tb_iter_square;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  iter_square_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) sq ();

  iter_square #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation from an idle block: accept, wait for done, check result.
  task automatic run_op(input string tag, input logic [15:0] x,
                        input logic [31:0] exp_y, input logic exp_neg);
    int          cyc;
    int          busy_cyc;
    logic [31:0] y_prev;
    logic        stable;
    sq.start = 1'b1;
    sq.x_in  = x;
    tick();
    sq.start = 1'b0;
    sq.x_in  = 16'h5A5A;
    y_prev   = sq.y_out;
    stable   = 1'b1;
    cyc      = 0;
    busy_cyc = sq.busy ? 1 : 0;
    while (!sq.done && cyc < 40) begin
      tick();
      cyc++;
      if (sq.busy) busy_cyc++;
      if (!sq.done && sq.y_out !== y_prev) stable = 1'b0;
    end
    check({tag, " latency"}, cyc, 16);
    check({tag, " busy_cycles"}, busy_cyc, 17);
    check({tag, " y_out"}, sq.y_out, exp_y);
    check({tag, " is_neg"}, sq.is_neg, exp_neg);
    check({tag, " y_stable_in_run"}, stable, 1);
    tick();
    check({tag, " done_pulse_len"}, sq.done, 0);
    check({tag, " idle_after_fin"}, sq.busy, 0);
    check({tag, " y_held"}, sq.y_out, exp_y);
  endtask

  initial begin
    int          dones;
    int          t_first;
    int          t_second;
    logic [31:0] y_first;
    logic [31:0] y_second;
    logic        stable;

    rst_n    = 1'b0;
    sq.start = 1'b0;
    sq.x_in  = '0;
    repeat (3) tick();
    check("reset done", sq.done, 0);
    check("reset busy", sq.busy, 0);
    check("reset y_out", sq.y_out, 0);
    check("reset is_neg", sq.is_neg, 0);
    rst_n = 1'b1;
    tick();

    run_op("zero", 16'd0, 32'd0, 1'b0);
    run_op("x255", 16'd255, 32'd65025, 1'b0);
    run_op("x32767", 16'd32767, 32'd1073676289, 1'b0);
    run_op("xm3", 16'hFFFD, 32'd9, 1'b1);
    run_op("xm32768", 16'h8000, 32'h4000_0000, 1'b1);

    // start pulsed during RUN must be ignored
    sq.start = 1'b1;
    sq.x_in  = 16'd7;
    tick();
    sq.start = 1'b0;
    repeat (3) tick();
    sq.start = 1'b1;
    sq.x_in  = 16'd100;
    repeat (2) tick();
    sq.start = 1'b0;
    dones   = 0;
    y_first = '0;
    for (int i = 0; i < 40; i++) begin
      if (sq.done) begin
        dones++;
        y_first = sq.y_out;
      end
      tick();
    end
    check("ignore_start dones", dones, 1);
    check("ignore_start y_out", y_first, 49);
    check("ignore_start is_neg", sq.is_neg, 0);

    // back-to-back with start held high
    sq.start = 1'b1;
    sq.x_in  = 16'd12;
    tick();
    sq.x_in  = 16'd5;
    dones    = 0;
    t_first  = -1;
    t_second = -1;
    y_first  = '0;
    y_second = '0;
    stable   = 1'b1;
    for (int i = 0; i < 60 && dones < 2; i++) begin
      if (sq.done) begin
        dones++;
        if (dones == 1) begin
          t_first = i;
          y_first = sq.y_out;
        end else begin
          t_second = i;
          y_second = sq.y_out;
          sq.start = 1'b0;
        end
      end else if (dones == 1 && sq.y_out !== y_first) begin
        stable = 1'b0;
      end
      tick();
    end
    sq.start = 1'b0;
    check("b2b dones", dones, 2);
    check("b2b spacing", t_second - t_first, 18);
    check("b2b y_first", y_first, 144);
    check("b2b y_second", y_second, 25);
    check("b2b y_stable_between", stable, 1);
    repeat (2) tick();
    check("b2b idle_after", sq.busy, 0);

    // reset in the 8th RUN cycle aborts without a done pulse
    sq.start = 1'b1;
    sq.x_in  = 16'd9;
    tick();
    sq.start = 1'b0;
    dones    = 0;
    for (int i = 0; i < 7; i++) begin
      if (sq.done) dones++;
      tick();
    end
    check("abort busy_before_reset", sq.busy, 1);
    rst_n = 1'b0;
    tick();
    if (sq.done) dones++;
    check("abort dones", dones, 0);
    check("abort busy", sq.busy, 0);
    check("abort y_out", sq.y_out, 0);
    check("abort is_neg", sq.is_neg, 0);
    rst_n = 1'b1;
    run_op("after_reset", 16'd9, 32'd81, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
